// File: rtl/wall_sequencer_if.sv
// Bus between the breakout wall controller, the VGA timing generator and the block array.
// The slave side belongs to wall_sequencer; the master side drives timing, block flags and player events.
interface wall_sequencer_if #(
   parameter int NUM_BLOCKS = 12,
   parameter int SCORE_W    = 10
);
   logic                  pixpulse;
   logic [9:0]            hcount;
   logic [9:0]            vcount;
   logic [NUM_BLOCKS-1:0] broken;
   logic                  start;
   logic                  ball_lost;

   logic                  move;
   logic                  unbreak;
   logic [SCORE_W-1:0]    score;
   logic [2:0]            lives;
   logic [3:0]            level;
   logic                  game_over;

   modport master (
      output pixpulse, hcount, vcount, broken, start, ball_lost,
      input  move, unbreak, score, lives, level, game_over
   );

   modport slave (
      input  pixpulse, hcount, vcount, broken, start, ball_lost,
      output move, unbreak, score, lives, level, game_over
   );
endinterface

// File: rtl/wall_sequencer.sv
// Breakout game-level controller: frame-tick move strobe, wall rebuild strobe,
// scoring of newly broken blocks, lives, level and game-over tracking.
module wall_sequencer #(
   parameter int NUM_BLOCKS   = 12,
   parameter int H_TICK       = 0,
   parameter int V_TICK       = 481,
   parameter int LIVES_INIT   = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int SCORE_W      = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   wall_sequencer_if.slave bus
);
   localparam int HIT_W = $clog2(NUM_BLOCKS + 1);
   localparam int SUM_W = SCORE_W + HIT_W;

   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [2:0]         LIVES_LOAD = 3'(LIVES_INIT);
   localparam logic [7:0]         LAST_FRAME = 8'(SERVE_FRAMES - 1);
   localparam logic [9:0]         H_TICK_V   = 10'(H_TICK);
   localparam logic [9:0]         V_TICK_V   = 10'(V_TICK);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WALL,
      S_SERVE,
      S_PLAY,
      S_CLEAR,
      S_OVER
   } state_e;

   state_e                state_q,     state_d;
   logic [7:0]            frames_q,    frames_d;
   logic                  wall_sent_q, wall_sent_d;
   logic                  move_q,      move_d;
   logic                  unbreak_q,   unbreak_d;
   logic [SCORE_W-1:0]    score_q,     score_d;
   logic [2:0]            lives_q,     lives_d;
   logic [3:0]            level_q,     level_d;
   logic [NUM_BLOCKS-1:0] broken_q;

   logic                  tick;
   logic                  all_broken;
   logic [NUM_BLOCKS-1:0] new_bits;
   logic [HIT_W-1:0]      hits;
   logic [SUM_W-1:0]      score_sum;

   assign tick       = bus.pixpulse && (bus.hcount == H_TICK_V) && (bus.vcount == V_TICK_V);
   assign all_broken = &bus.broken;

   // Blocks that went broken since the previous pixpulse; only these score.
   always_comb begin
      new_bits = bus.broken & ~broken_q;
      hits     = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         hits = hits + HIT_W'(new_bits[i]);
      end
      score_sum = SUM_W'(score_q) + SUM_W'(hits);
   end

   always_comb begin
      // NOTE: every next-state value starts from its register so no path leaves one unassigned (no latches).
      state_d     = state_q;
      frames_d    = frames_q;
      wall_sent_d = wall_sent_q;
      move_d      = move_q;
      unbreak_d   = unbreak_q;
      score_d     = score_q;
      lives_d     = lives_q;
      level_d     = level_q;

      if (bus.pixpulse) begin
         // A strobe raised on one pixpulse is seen by the blocks on the next and then drops.
         move_d    = 1'b0;
         unbreak_d = 1'b0;

         unique case (state_q)
            S_IDLE, S_OVER: begin
               if (bus.start) begin
                  state_d     = S_WALL;
                  wall_sent_d = 1'b0;
                  score_d     = '0;
                  lives_d     = LIVES_LOAD;
                  level_d     = '0;
               end
            end

            S_WALL: begin
               if (!wall_sent_q) begin
                  unbreak_d   = 1'b1;
                  wall_sent_d = 1'b1;
               end else if (!unbreak_q) begin
                  state_d  = S_SERVE;
                  frames_d = '0;
               end
            end

            S_SERVE: begin
               if (tick) begin
                  frames_d = frames_q + 8'd1;
                  if (frames_q == LAST_FRAME) state_d = S_PLAY;
               end
            end

            S_PLAY: begin
               score_d = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
               if (tick) move_d = 1'b1;
               // A full wall takes priority over a lost ball in the same cycle.
               if (all_broken) begin
                  state_d  = S_CLEAR;
                  frames_d = '0;
               end else if (bus.ball_lost) begin
                  if (lives_q == 3'd1) begin
                     lives_d = '0;
                     state_d = S_OVER;
                  end else begin
                     lives_d  = lives_q - 3'd1;
                     state_d  = S_SERVE;
                     frames_d = '0;
                  end
               end
            end

            S_CLEAR: begin
               if (tick) begin
                  frames_d = frames_q + 8'd1;
                  if (frames_q == LAST_FRAME) begin
                     level_d     = level_q + 4'd1;
                     state_d     = S_WALL;
                     wall_sent_d = 1'b0;
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         frames_q    <= '0;
         wall_sent_q <= 1'b0;
         move_q      <= 1'b0;
         unbreak_q   <= 1'b0;
         score_q     <= '0;
         lives_q     <= LIVES_LOAD;
         level_q     <= '0;
         broken_q    <= '0;
      end else begin
         // NOTE: non-blocking so every register updates from the values present before this edge.
         state_q     <= state_d;
         frames_q    <= frames_d;
         wall_sent_q <= wall_sent_d;
         move_q      <= move_d;
         unbreak_q   <= unbreak_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         if (bus.pixpulse) broken_q <= bus.broken;
      end
   end

   assign bus.move      = move_q;
   assign bus.unbreak   = unbreak_q;
   assign bus.score     = score_q;
   assign bus.lives     = lives_q;
   assign bus.level     = level_q;
   assign bus.game_over = (state_q == S_OVER);
endmodule

// File: tb/tb_wall_sequencer.sv
// Randomized self-checking bench for wall_sequencer against a game-level reference model.
module tb_wall_sequencer;
   localparam int NB    = 12;
   localparam int SW    = 10;
   localparam int LIVES = 3;
   localparam int SERVE = 60;
   localparam int FRAME = 8;
   localparam int SMAX  = (1 << SW) - 1;
   localparam logic [NB-1:0] NOT_ALL = {1'b0, {(NB-1){1'b1}}};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wall_sequencer_if #(.NUM_BLOCKS(NB), .SCORE_W(SW)) bus();

   wall_sequencer #(
      .NUM_BLOCKS(NB), .H_TICK(0), .V_TICK(481), .LIVES_INIT(LIVES),
      .SERVE_FRAMES(SERVE), .SCORE_W(SW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Game model: the wall rebuild is treated as instantaneous, so it tracks phases
   // of play rather than controller states.
   typedef enum {G_IDLE, G_SERVE, G_PLAY, G_CLEAR, G_OVER} game_e;
   game_e       g_mode;
   int          g_ticks, e_score, e_lives, e_level, e_unbreaks;
   logic        e_move;
   logic [NB-1:0] g_prev, br_drv;
   int          ph, o_unbreaks, o_overlap, o_moves;

   task automatic model_reset();
      g_mode  = G_IDLE;
      g_ticks = 0;
      e_score = 0;
      e_lives = LIVES;
      e_level = 0;
      e_move  = 1'b0;
      g_prev  = '0;
   endtask

   // One pixpulse period (4 clocks): drive, let the edge happen, advance model, compare.
   task automatic step(input bit st, input bit bl);
      bit tick;
      int hits;
      tick = (ph == FRAME - 1);
      repeat (2) begin
         @(negedge clk);
         bus.pixpulse  = 1'b0;
         bus.hcount    = 10'd0;
         bus.vcount    = 10'd481;
         bus.start     = st;
         bus.broken    = br_drv;
         bus.ball_lost = 1'b0;
      end
      @(negedge clk);
      bus.pixpulse  = 1'b1;
      bus.ball_lost = bl;
      if (tick) begin
         bus.hcount = 10'd0;
         bus.vcount = 10'd481;
      end else begin
         case ($urandom_range(0, 2))
            0:       begin bus.hcount = 10'($urandom_range(1, 799)); bus.vcount = 10'd481; end
            1:       begin bus.hcount = 10'd0; bus.vcount = 10'd480; end
            default: begin bus.hcount = 10'd0; bus.vcount = 10'($urandom_range(482, 524)); end
         endcase
      end
      @(negedge clk);
      bus.pixpulse  = 1'b0;
      bus.ball_lost = 1'b0;
      bus.start     = 1'b0;

      hits   = $countones(br_drv & ~g_prev);
      e_move = 1'b0;
      case (g_mode)
         G_IDLE, G_OVER: if (st) begin
            e_score = 0; e_lives = LIVES; e_level = 0;
            e_unbreaks++;
            g_mode = G_SERVE; g_ticks = 0;
         end
         G_SERVE: if (tick) begin
            g_ticks++;
            if (g_ticks == SERVE) g_mode = G_PLAY;
         end
         G_PLAY: begin
            e_score = (e_score + hits > SMAX) ? SMAX : e_score + hits;
            if (tick) e_move = 1'b1;
            if (&br_drv) begin
               g_mode = G_CLEAR; g_ticks = 0;
            end else if (bl) begin
               if (e_lives == 1) begin
                  e_lives = 0; g_mode = G_OVER;
               end else begin
                  e_lives--; g_mode = G_SERVE; g_ticks = 0;
               end
            end
         end
         G_CLEAR: if (tick) begin
            g_ticks++;
            if (g_ticks == SERVE) begin
               e_level = (e_level + 1) % 16;
               e_unbreaks++;
               g_mode = G_SERVE; g_ticks = 0;
            end
         end
         default: ;
      endcase
      g_prev = br_drv;
      ph = (ph + 1) % FRAME;

      check("score", bus.score, e_score);
      check("lives", bus.lives, e_lives);
      check("level", bus.level, e_level);
      check("game_over", bus.game_over, (g_mode == G_OVER));
      check("move", bus.move, e_move);
      if (bus.move) o_moves++;
      if (bus.move && bus.unbreak) o_overlap++;
      if (bus.unbreak) begin
         o_unbreaks++;
         br_drv = '0;   // the blocks rebuild on the strobe
      end
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic goto_phase(input int p);
      while (ph != p) step(1'b0, 1'b0);
   endtask

   // Waits out SERVE or CLEAR while throwing in start and ball_lost pulses that must be ignored.
   task automatic wait_leave(input game_e m);
      int guard;
      guard = 0;
      while (g_mode == m && guard < (SERVE + 4) * FRAME) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
         guard++;
      end
   endtask

   task automatic play_random(input int n);
      repeat (n) begin
         if (g_mode == G_PLAY) begin
            case ($urandom_range(0, 3))
               0:       br_drv = (br_drv | NB'($urandom)) & NOT_ALL;
               1:       br_drv = br_drv & NB'($urandom);
               default: ;
            endcase
         end
         step(1'b0, 1'b0);
      end
   endtask

   task automatic checkpoint(input string tag);
      check({tag, "_unbreaks"}, o_unbreaks, e_unbreaks);
      check({tag, "_overlap"}, o_overlap, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_move"}, bus.move, 0);
      check({tag, "_unbreak"}, bus.unbreak, 0);
      check({tag, "_score"}, bus.score, 0);
      check({tag, "_lives"}, bus.lives, LIVES);
      check({tag, "_level"}, bus.level, 0);
      check({tag, "_game_over"}, bus.game_over, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_ticks;
      bit  seen;
      int  moves_before;
      int  score_clear;
      int  k;

      bus.pixpulse = 1'b0; bus.hcount = '0; bus.vcount = '0;
      bus.broken = '0; bus.start = 1'b0; bus.ball_lost = 1'b0;
      br_drv = '0; ph = 0;
      e_unbreaks = 0; o_unbreaks = 0; o_overlap = 0; o_moves = 0;
      model_reset();

      #12;
      check_reset_values("por");
      @(negedge clk);
      rst_n = 1'b1;

      // IDLE ignores ball_lost and block activity.
      for (int i = 0; i < 2 * FRAME; i++) begin
         br_drv = NB'($urandom);
         step(1'b0, (i % 5 == 0));
      end
      br_drv = '0;
      step(1'b0, 1'b0);
      checkpoint("idle");

      // Game 1: first move comes on the tick after SERVE ticks.
      goto_phase(1);
      step(1'b1, 1'b0);
      check("start_score", bus.score, 0);
      check("start_lives", bus.lives, LIVES);
      n_ticks = 0;
      seen    = 1'b0;
      for (int i = 0; i < (SERVE + 4) * FRAME && !seen; i++) begin
         if (ph == FRAME - 1) n_ticks++;
         step(1'b0, 1'b0);
         seen = bus.move;
      end
      check("first_move_tick", n_ticks, SERVE + 1);
      checkpoint("wall1");

      goto_phase(2);
      br_drv = 12'h005;
      step(1'b0, 1'b0);
      check("score_005", bus.score, 2);
      run(FRAME);
      br_drv = 12'h007;
      step(1'b0, 1'b0);
      check("score_007", bus.score, 3);

      play_random(6 * FRAME);
      goto_phase(3);
      step(1'b0, 1'b1);
      check("lives_loss1", bus.lives, 2);
      wait_leave(G_SERVE);

      // Drive the score to one below full scale, then saturate it.
      while (e_score < SMAX - 1) begin
         br_drv = '0;
         step(1'b0, 1'b0);
         k = SMAX - 1 - e_score;
         if (k > NB - 1) k = NB - 1;
         br_drv = NB'((1 << k) - 1);
         step(1'b0, 1'b0);
      end
      check("score_1022", bus.score, SMAX - 1);
      br_drv = '0;
      step(1'b0, 1'b0);
      br_drv = 12'h070;
      step(1'b0, 1'b0);
      check("score_sat", bus.score, SMAX);
      br_drv = NOT_ALL;
      step(1'b0, 1'b0);
      check("score_hold", bus.score, SMAX);

      // Ball lost on a tick: that tick still moves but does not count toward SERVE.
      goto_phase(FRAME - 1);
      step(1'b0, 1'b1);
      check("lives_loss2", bus.lives, 1);
      wait_leave(G_SERVE);
      play_random(2 * FRAME);

      goto_phase(FRAME - 1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("lives_over", bus.lives, 0);
      check("game_over_set", bus.game_over, 1);
      moves_before = o_moves;
      for (int i = 0; i < 4 * FRAME; i++) begin
         br_drv = NB'($urandom) & NOT_ALL;
         step(1'b0, (i % 7 == 3));
      end
      check("over_no_move", o_moves - moves_before, 0);
      check("over_score", bus.score, SMAX);
      checkpoint("game1");

      // Game 2: restart from OVER, clear the wall while losing the ball in the same cycle.
      br_drv = '0;
      goto_phase(2);
      step(1'b1, 1'b0);
      check("restart_score", bus.score, 0);
      check("restart_lives", bus.lives, LIVES);
      check("restart_game_over", bus.game_over, 0);
      wait_leave(G_SERVE);
      play_random(4 * FRAME);

      goto_phase(3);
      br_drv = '1;
      step(1'b0, 1'b1);
      check("clear_lives", bus.lives, LIVES);
      score_clear = e_score;
      wait_leave(G_CLEAR);
      run(FRAME);
      check("clear_level", bus.level, 1);
      check("rebuild_score", bus.score, score_clear);
      checkpoint("clear");

      wait_leave(G_SERVE);
      play_random(3 * FRAME);
      goto_phase(4);
      step(1'b0, 1'b1);
      check("lives_loss3", bus.lives, 2);
      wait_leave(G_SERVE);
      br_drv = '0;
      step(1'b0, 1'b0);
      br_drv = 12'h030;
      step(1'b0, 1'b0);
      play_random(FRAME);

      // Asynchronous reset while a move strobe is high.
      goto_phase(FRAME - 1);
      step(1'b0, 1'b0);
      check("move_before_rst", bus.move, 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 2 * FRAME; i++) step(1'b0, (i == 5));
      checkpoint("post_rst_idle");
      goto_phase(1);
      step(1'b1, 1'b0);
      run(FRAME);
      checkpoint("post_rst_start");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
